// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_unit
//  Purpose  : Memory stage behind the ALU. Issues byte/half/word loads and
//             stores over a req/ack data-memory handshake, stalls the core
//             until completion, formats load data, flags misalignment and
//             memory time-outs.
//  Revision : 1.0  initial release
// ============================================================================
module mem_access_unit #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mem_rd,
   input  logic        mem_wr,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [1:0]  size,
   input  logic        sign_ext,
   output logic [31:0] rdata,
   output logic        stall,
   output logic        addr_err,
   output logic        bus_err,
   output logic        m_req,
   output logic        m_we,
   output logic [29:0] m_addr,
   output logic [3:0]  m_be,
   output logic [31:0] m_wdata,
   input  logic        m_ack,
   input  logic [31:0] m_rdata
);

   // Last counter value before the access is abandoned.
   localparam logic [7:0] C_CNT_LAST = 8'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic [7:0]  r_cnt;
   logic [1:0]  r_off;
   logic [1:0]  r_size;
   logic        r_sext;

   logic        w_access;
   logic        w_aligned;
   logic        w_start;
   logic        w_timeout;
   logic [3:0]  w_be;
   logic [31:0] w_wdata;
   logic [31:0] w_fmt;
   logic [7:0]  w_byte;
   logic [15:0] w_half;

   assign w_access  = mem_rd | mem_wr;
   assign w_start   = (r_state == IDLE) && w_access && w_aligned;
   // Ack in the last permitted cycle takes priority over the time-out.
   assign w_timeout = (r_state == BUSY) && !m_ack && (r_cnt == C_CNT_LAST);

   // Alignment check, byte enables and lane-replicated store data per size.
   always_comb begin
      w_aligned = 1'b1;
      w_be      = 4'b1111;
      w_wdata   = wdata;
      case (size)
         2'b00: begin
            w_aligned = 1'b1;
            w_be      = 4'b0001 << addr[1:0];
            w_wdata   = {4{wdata[7:0]}};
         end
         2'b01: begin
            w_aligned = ~addr[0];
            w_be      = addr[1] ? 4'b1100 : 4'b0011;
            w_wdata   = {2{wdata[15:0]}};
         end
         default: begin
            // Reserved size code behaves as a word access.
            w_aligned = (addr[1:0] == 2'b00);
            w_be      = 4'b1111;
            w_wdata   = wdata;
         end
      endcase
   end

   // Lane selection and extension of the returned read word.
   always_comb begin
      w_byte = m_rdata[7:0];
      case (r_off)
         2'b00:   w_byte = m_rdata[7:0];
         2'b01:   w_byte = m_rdata[15:8];
         2'b10:   w_byte = m_rdata[23:16];
         default: w_byte = m_rdata[31:24];
      endcase
      w_half = r_off[1] ? m_rdata[31:16] : m_rdata[15:0];
      case (r_size)
         2'b00:   w_fmt = {{24{r_sext & w_byte[7]}}, w_byte};
         2'b01:   w_fmt = {{16{r_sext & w_half[15]}}, w_half};
         default: w_fmt = m_rdata;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   // Next state, stall and misalignment pulse; all forced low while in reset.
   always_comb begin
      w_next   = r_state;
      stall    = 1'b0;
      addr_err = 1'b0;
      if (rst_n) begin
         case (r_state)
            IDLE: begin
               if (w_access) begin
                  if (w_aligned) begin
                     stall  = 1'b1;
                     w_next = BUSY;
                  end else begin
                     addr_err = 1'b1;
                  end
               end
            end
            BUSY: begin
               stall = 1'b1;
               if (m_ack || w_timeout) w_next = DONE;
            end
            DONE: begin
               // A request seen here belongs to the completing instruction.
               w_next = IDLE;
            end
            default: w_next = IDLE;
         endcase
      end
   end

   // Memory port registers, access context, time-out counter and load result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_req   <= 1'b0;
         m_we    <= 1'b0;
         m_addr  <= '0;
         m_be    <= '0;
         m_wdata <= '0;
         rdata   <= '0;
         bus_err <= 1'b0;
         r_cnt   <= '0;
         r_off   <= '0;
         r_size  <= '0;
         r_sext  <= 1'b0;
      end else begin
         bus_err <= 1'b0;
         if (w_start) begin
            m_req   <= 1'b1;
            m_we    <= mem_wr;
            m_addr  <= addr[31:2];
            m_be    <= w_be;
            m_wdata <= w_wdata;
            r_cnt   <= '0;
            r_off   <= addr[1:0];
            r_size  <= size;
            r_sext  <= sign_ext;
         end else if (r_state == BUSY) begin
            if (m_ack) begin
               m_req <= 1'b0;
               m_we  <= 1'b0;
               if (!m_we) rdata <= w_fmt;
            end else if (w_timeout) begin
               m_req   <= 1'b0;
               m_we    <= 1'b0;
               bus_err <= 1'b1;
            end else begin
               r_cnt <= r_cnt + 8'd1;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_access_unit
//  Purpose  : Directed self-checking bench for mem_access_unit.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_access_unit;

   logic        clk;
   logic        rst_n;
   logic        mem_rd;
   logic        mem_wr;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [1:0]  size;
   logic        sign_ext;
   logic [31:0] rdata;
   logic        stall;
   logic        addr_err;
   logic        bus_err;
   logic        m_req;
   logic        m_we;
   logic [29:0] m_addr;
   logic [3:0]  m_be;
   logic [31:0] m_wdata;
   logic        m_ack;
   logic [31:0] m_rdata;

   int vectors = 0;
   int errs    = 0;
   int req_cycles;

   mem_access_unit #(.TIMEOUT(16)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .mem_rd   (mem_rd),
      .mem_wr   (mem_wr),
      .addr     (addr),
      .wdata    (wdata),
      .size     (size),
      .sign_ext (sign_ext),
      .rdata    (rdata),
      .stall    (stall),
      .addr_err (addr_err),
      .bus_err  (bus_err),
      .m_req    (m_req),
      .m_we     (m_we),
      .m_addr   (m_addr),
      .m_be     (m_be),
      .m_wdata  (m_wdata),
      .m_ack    (m_ack),
      .m_rdata  (m_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         errs++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic nxt();
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b1; mem_rd = 1'b0; mem_wr = 1'b0; addr = '0; wdata = '0;
      size = 2'b00; sign_ext = 1'b0; m_ack = 1'b0; m_rdata = '0;
      #1 rst_n = 1'b0;
      #1;
      chk("rst_rdata", rdata, 32'h0);
      chk("rst_stall", {31'h0, stall}, 32'h0);
      chk("rst_m_req", {31'h0, m_req}, 32'h0);
      chk("rst_m_addr", {2'b00, m_addr}, 32'h0);
      chk("rst_m_be", {28'h0, m_be}, 32'h0);
      chk("rst_errs", {30'h0, addr_err, bus_err}, 32'h0);
      nxt; nxt;
      rst_n = 1'b1;

      // Aligned word load, ack in the first BUSY cycle.
      nxt;
      mem_rd = 1'b1; addr = 32'h0000_0010; size = 2'b10;
      #1 chk("wl_stall_c0", {31'h0, stall}, 32'h1);
      nxt; #1;
      chk("wl_m_req", {31'h0, m_req}, 32'h1);
      chk("wl_m_addr", {2'b00, m_addr}, 32'h4);
      chk("wl_m_be", {28'h0, m_be}, 32'hF);
      chk("wl_m_we", {31'h0, m_we}, 32'h0);
      chk("wl_stall_c1", {31'h0, stall}, 32'h1);
      m_ack = 1'b1; m_rdata = 32'hDEAD_BEEF;
      nxt;
      m_ack = 1'b0; m_rdata = '0;
      #1;
      chk("wl_stall_done", {31'h0, stall}, 32'h0);
      chk("wl_rdata", rdata, 32'hDEAD_BEEF);
      chk("wl_m_req_done", {31'h0, m_req}, 32'h0);
      mem_rd = 1'b0;
      nxt; #1;
      chk("wl_idle_stall", {31'h0, stall}, 32'h0);

      // Byte load at offset 3, sign-extended.
      mem_rd = 1'b1; addr = 32'h0000_0103; size = 2'b00; sign_ext = 1'b1;
      nxt; #1;
      chk("bl_m_be", {28'h0, m_be}, 32'h8);
      chk("bl_m_addr", {2'b00, m_addr}, 32'h40);
      m_ack = 1'b1; m_rdata = 32'h80FF_1234;
      nxt; m_ack = 1'b0; #1;
      chk("bl_sext", rdata, 32'hFFFF_FF80);
      mem_rd = 1'b0;
      nxt;
      // Same byte, zero-extended.
      mem_rd = 1'b1; sign_ext = 1'b0;
      nxt; #1;
      m_ack = 1'b1; m_rdata = 32'h80FF_1234;
      nxt; m_ack = 1'b0; #1;
      chk("bl_zext", rdata, 32'h0000_0080);
      mem_rd = 1'b0;
      nxt;

      // Half store at offset 2.
      mem_wr = 1'b1; addr = 32'h0000_0202; size = 2'b01; wdata = 32'h0000_ABCD;
      #1 chk("hs_stall_c0", {31'h0, stall}, 32'h1);
      nxt; #1;
      chk("hs_m_we", {31'h0, m_we}, 32'h1);
      chk("hs_m_be", {28'h0, m_be}, 32'hC);
      chk("hs_m_wdata", m_wdata, 32'hABCD_ABCD);
      m_ack = 1'b1; m_rdata = 32'h1111_1111;
      nxt; m_ack = 1'b0; #1;
      chk("hs_rdata_kept", rdata, 32'h0000_0080);
      chk("hs_m_we_drop", {31'h0, m_we}, 32'h0);
      mem_wr = 1'b0;
      nxt;

      // Half load, sign-extended, two-cycle memory latency.
      mem_rd = 1'b1; addr = 32'h0000_0302; size = 2'b01; sign_ext = 1'b1;
      nxt; #1;
      chk("hl_m_be", {28'h0, m_be}, 32'hC);
      nxt; #1;
      chk("hl_stall_wait", {31'h0, stall}, 32'h1);
      chk("hl_m_req_wait", {31'h0, m_req}, 32'h1);
      m_ack = 1'b1; m_rdata = 32'h80FF_1234;
      nxt; m_ack = 1'b0; #1;
      chk("hl_rdata", rdata, 32'hFFFF_80FF);
      chk("hl_stall_done", {31'h0, stall}, 32'h0);
      mem_rd = 1'b0;
      nxt;

      // Misaligned word load.
      mem_rd = 1'b1; addr = 32'h0000_0006; size = 2'b10;
      #1;
      chk("ma_addr_err", {31'h0, addr_err}, 32'h1);
      chk("ma_stall", {31'h0, stall}, 32'h0);
      nxt; #1;
      chk("ma_no_req", {31'h0, m_req}, 32'h0);
      mem_rd = 1'b0;
      #1 chk("ma_err_clear", {31'h0, addr_err}, 32'h0);

      // Time-out: no ack at all.
      nxt;
      mem_rd = 1'b1; addr = 32'h0000_0020; size = 2'b10;
      req_cycles = 0;
      for (int i = 0; i < 40; i++) begin
         nxt; #1;
         if (m_req) req_cycles++;
         else break;
      end
      chk("to_req_cycles", req_cycles, 32'd16);
      chk("to_bus_err", {31'h0, bus_err}, 32'h1);
      chk("to_stall_done", {31'h0, stall}, 32'h0);
      chk("to_rdata_kept", rdata, 32'hFFFF_80FF);
      mem_rd = 1'b0;
      nxt; #1;
      chk("to_bus_err_pulse", {31'h0, bus_err}, 32'h0);

      // Ack in the 16th BUSY cycle beats the time-out.
      mem_rd = 1'b1; addr = 32'h0000_0024;
      for (int i = 0; i < 15; i++) nxt;
      #1 chk("ta_still_req", {31'h0, m_req}, 32'h1);
      nxt;
      m_ack = 1'b1; m_rdata = 32'h1234_5678;
      nxt; m_ack = 1'b0; #1;
      chk("ta_no_bus_err", {31'h0, bus_err}, 32'h0);
      chk("ta_rdata", rdata, 32'h1234_5678);
      chk("ta_stall_done", {31'h0, stall}, 32'h0);
      mem_rd = 1'b0;
      nxt;

      // Asynchronous reset in BUSY.
      mem_rd = 1'b1; addr = 32'h0000_0030;
      nxt; #1;
      chk("ar_m_req_busy", {31'h0, m_req}, 32'h1);
      #1 rst_n = 1'b0;
      #1;
      chk("ar_m_req", {31'h0, m_req}, 32'h0);
      chk("ar_stall", {31'h0, stall}, 32'h0);
      chk("ar_bus_err", {31'h0, bus_err}, 32'h0);
      mem_rd = 1'b0;
      nxt;
      rst_n = 1'b1;
      nxt; #1;
      chk("ar_idle_after", {30'h0, stall, m_req}, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
`default_nettype wire
